// File: rtl/half_argmax_stream.sv
// half_argmax_stream
//
// Streaming FP16 arg-max reducer. It accepts one half-precision element per
// valid/ready beat and reports the largest element of each vector and its
// zero-based position. The ordering matches the pairwise max compare stage:
// a positive value beats a negative one (+0 beats -0), positives order by
// {exp,mant} ascending, and negatives order by {exp,mant} descending. NaN and
// Inf get no special treatment. On a tie the earlier element is kept.
//
// A vector ends on the beat that carries in_last, or on beat VEC_LEN-1,
// whichever comes first. out_len_err is set when those two disagree. After a
// vector ends, the block holds the result until out_ready and accepts no
// input during that time.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   in_data      FP16 element (sign[15], exp[14:10], mant[9:0])
//   in_valid     in_data valid
//   in_last      final element of the vector, qualified by in_valid
//   in_ready     block can accept an element
//   out_max      maximum element of the completed vector
//   out_idx      position of out_max within the vector
//   out_len_err  vector length disagreed with VEC_LEN
//   out_valid    result valid
//   out_ready    downstream accepts the result
module half_argmax_stream #(
  parameter int VEC_LEN = 10,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_len_err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(VEC_LEN - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] count;
  logic [15:0]      run_max;
  logic [IDX_W-1:0] run_idx;
  logic [15:0]      cur_max;
  logic [IDX_W-1:0] cur_idx;
  logic             accept;
  logic             at_end;
  logic             terminate;
  logic             take;

  // Returns 1 when a is strictly larger than b under the FP16 sign-magnitude
  // ordering. Bit-identical operands are never "larger", so ties keep the
  // element that came first.
  function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
    logic gt;
    if (a[15] != b[15])
      gt = b[15];
    else if (!a[15])
      gt = (a[14:0] > b[14:0]);
    else
      gt = (a[14:0] < b[14:0]);
    return gt;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ACCUM;
    else
      state <= state_next;
  end

  // Next-state logic. There is no path from DONE straight into a new
  // vector, because the block always passes through ACCUM first.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && terminate) state_next = DONE;
      DONE:    if (out_ready)           state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake outputs depend only on the state.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // Running max including the current beat. The first beat of a vector
  // always loads, whatever the stale contents of run_max are.
  always_comb begin
    accept    = in_valid && in_ready;
    at_end    = (count == LAST_POS);
    terminate = in_last || at_end;
    take      = (count == '0) || fp16_gt(in_data, run_max);
    cur_max   = take ? in_data : run_max;
    cur_idx   = take ? count   : run_idx;
  end

  // Datapath registers. Results are updated only on a terminating beat, so
  // they hold through DONE and after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      run_max     <= 16'h0000;
      run_idx     <= '0;
      out_max     <= 16'h0000;
      out_idx     <= '0;
      out_len_err <= 1'b0;
    end else if (accept) begin
      run_max <= cur_max;
      run_idx <= cur_idx;
      if (terminate) begin
        out_max     <= cur_max;
        out_idx     <= cur_idx;
        out_len_err <= (in_last != at_end);
        count       <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: doc/half_argmax_stream.md
Name: half_argmax_stream

Overview:
- Streaming FP16 arg-max reducer that sits downstream of the pairwise half-precision max compare.
- Consumes a vector of VEC_LEN half-precision values, one per accepted beat, using a valid/ready handshake.
- Emits the maximum value and its index once per vector.
- Used as the classifier output stage after the final dense layer.

Parameters:
- VEC_LEN, 10, nominal number of elements per vector (≥2).
- IDX_W, 4, width of index/count fields; must satisfy 2**IDX_W ≥ VEC_LEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  16  FP16 element (sign[15], exp[14:10], mant[9:0])
- in_valid  input  1  in_data valid
- in_last  input  1  marks final element of the vector; qualified by in_valid
- in_ready  output  1  block can accept an element
- out_max  output  16  maximum element of the completed vector
- out_idx  output  IDX_W  zero-based position of out_max in the vector
- out_len_err  output  1  vector length disagreed with VEC_LEN
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst=1 at clk edge) has priority over all other activity, including mid-vector and while holding an unaccepted result. Reset values:
  - state=ACCUM, count=0
  - out_max=16'h0000, out_idx=0, out_len_err=0, out_valid=0
  - in_ready=1 from the first cycle after reset
- Ordering rule (identical to the pairwise max stage):
  - Different signs: the positive operand is larger. +0 (0x0000) > -0 (0x8000).
  - Both positive: larger {exp,mant}, unsigned, is larger.
  - Both negative: smaller {exp,mant} is larger.
  - No NaN/Inf special casing; patterns order purely by the rule above.
- Ties (bit-identical values): keep the earliest index; a later equal element never replaces the running max.
- States:
  - ACCUM: in_ready=1, out_valid=0. On accept (in_valid & in_ready):
    - count==0: running max := in_data, idx := 0.
    - otherwise: replace running max/idx only if in_data is strictly larger.
    - Termination: the vector terminates on this beat if in_last=1 or count==VEC_LEN-1.
    - If not terminating: count++.
    - If terminating:
      - out_max/out_idx := final running max/idx, including the current beat.
      - out_len_err := (in_last != (count==VEC_LEN-1)).
      - count := 0, out_valid := 1, go to DONE.
  - DONE: in_ready=0. out_max/out_idx/out_len_err are stable while out_valid=1 and out_ready=0.
    - When out_valid & out_ready: out_valid := 0 and return to ACCUM next cycle.
    - No back-to-back overlap with the next vector.
- Latency: result visible (out_valid=1) on the cycle after the terminating beat is accepted.
- Throughput: one vector per ≥VEC_LEN+1 cycles.
- Single-element vector: in_last=1 on the first beat gives out_idx=0, out_max=in_data, out_len_err=1 (VEC_LEN≥2).
- Over-length input: with in_last=0 on beat VEC_LEN-1, the vector still terminates there and out_len_err=1. The next beat starts a new vector.
- Gaps: in_valid low in ACCUM holds all state; gaps of any length are legal.
- in_data/in_last are ignored when in_valid=0 or in_ready=0.
- out_max/out_idx keep their last result after acceptance until the next vector completes.
- Running max/idx registers are internal and not visible until termination.

Test Plan:
- Basic: VEC_LEN=10, elements 0x3C00,0x4000,0x3800,0x4200(3.0),0x3C00,0,0,0,0,0 with in_last on beat 9 -> out_max=0x4200, out_idx=3, out_len_err=0, out_valid one cycle after beat 9.
- All negative: 0xC000,0xBC00(-1.0),0xC200,… 0xC400 filling the rest -> out_max=0xBC00, out_idx=1.
- Ties and signed zero:
  - all ten = 0x3C00 -> out_idx=0.
  - vector 0x8000,0x0000, then 0x8000 for the rest -> out_max=0x0000, out_idx=1.
- Length errors:
  - in_last on beat 3 -> out_len_err=1, out_idx taken over beats 0..3 only.
  - in_last never asserted -> termination at beat 9, out_len_err=1, next beat lands at index 0 of a new vector.
- Backpressure: hold out_ready=0 for 5 cycles after result -> in_ready=0 and outputs stable throughout. Raise out_ready -> out_valid drops next cycle and in_ready=1.
- Reset mid-vector:
  - assert rst after 4 beats -> next vector of 10 beats reports only its own max and index.
  - assert rst during DONE -> out_valid=0 immediately and out_max=0x0000.
